// File: rtl/custom_types.sv
// Shared types and select codes for the 4-bit CPU control path.
package custom_types;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_LD   = 4'b0101,
    OP_ST   = 4'b0110,
    OP_JMP  = 4'b0111,
    OP_JZ   = 4'b1000,
    OP_HALT = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_operation_t;

  typedef enum logic [3:0] {
    INIT, FETCH, DECODE, EXEC, ALU_WB, MEM_RD, MEM_WR, JUMP, BRZ, HALT
  } ctrl_state_t;

  localparam logic [1:0] SRC1_PC   = 2'd0;
  localparam logic [1:0] SRC1_RD1  = 2'd1;
  localparam logic [1:0] SRC1_ZERO = 2'd2;
  localparam logic [1:0] SRC1_IMM2 = 2'd3;

  localparam logic [1:0] SRC2_RD2  = 2'd0;
  localparam logic [1:0] SRC2_IMM4 = 2'd1;
  localparam logic [1:0] SRC2_ONE  = 2'd2;
  localparam logic [1:0] SRC2_ZERO = 2'd3;

  localparam logic [1:0] RES_ALU_OUT    = 2'd0;
  localparam logic [1:0] RES_READ_DATA  = 2'd1;
  localparam logic [1:0] RES_ALU_RESULT = 2'd2;
  localparam logic [1:0] RES_IMM4       = 2'd3;

  function automatic logic is_alu_op(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode -> ALU function mapping; non-ALU opcodes select ADD.
module alu_decoder
  import custom_types::*;
(
  input  opcode_t        opcode_i,
  output alu_operation_t alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (opcode_i)
      OP_SUB:  alu_op_o = ALU_SUB;
      OP_AND:  alu_op_o = ALU_AND;
      OP_OR:   alu_op_o = ALU_OR;
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle FSM controller for the 4-bit CPU.
// Optional feature: CTRL_ILLEGAL_TRAP_EN traps undefined opcodes into HALT.
module control_unit
  import custom_types::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  opcode_t              opcode,
  input  logic                 zero,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 data_write,
  output logic                 alu_write,
  output logic                 zero_write,
  output logic [1:0]           alu_src1,
  output logic [1:0]           alu_src2,
  output alu_operation_t       alu_op,
  output logic [1:0]           result_src,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  ctrl_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 retire;
  alu_operation_t       dec_alu_op;

  alu_decoder u_alu_decoder (
    .opcode_i (opcode),
    .alu_op_o (dec_alu_op)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    data_write = 1'b0;
    alu_write  = 1'b0;
    zero_write = 1'b0;
    alu_src1   = SRC1_PC;
    alu_src2   = SRC2_RD2;
    alu_op     = ALU_ADD;
    result_src = RES_ALU_OUT;
    halted     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif

    case (state_q)
      INIT: state_d = FETCH;
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src1   = SRC1_PC;
        alu_src2   = SRC2_ONE;
        alu_op     = ALU_ADD;
        result_src = RES_ALU_RESULT;
        state_d    = DECODE;
      end
      DECODE: begin
        if (is_alu_op(opcode)) begin
          state_d = EXEC;
        end else begin
          case (opcode)
            OP_NOP:  begin state_d = FETCH; retire = 1'b1; end
            OP_LD:   state_d = MEM_RD;
            OP_ST:   state_d = MEM_WR;
            OP_JMP:  state_d = JUMP;
            OP_JZ:   state_d = BRZ;
            OP_HALT: begin state_d = HALT; retire = 1'b1; end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              state_d   = HALT;
              illegal_d = 1'b1;
`else
              state_d = FETCH;
              retire  = 1'b1;
`endif
            end
          endcase
        end
      end
      EXEC: begin
        alu_src1   = SRC1_RD1;
        alu_src2   = SRC2_RD2;
        alu_op     = dec_alu_op;
        alu_write  = 1'b1;
        zero_write = 1'b1;
        state_d    = ALU_WB;
      end
      ALU_WB: begin
        result_src = RES_ALU_OUT;
        reg_write  = 1'b1;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      MEM_RD: begin
        result_src = RES_READ_DATA;
        reg_write  = 1'b1;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      MEM_WR: begin
        data_write = 1'b1;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      JUMP: begin
        result_src = RES_IMM4;
        pc_write   = 1'b1;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      BRZ: begin
        result_src = RES_IMM4;
        pc_write   = zero;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      HALT: halted = 1'b1;
      default: state_d = INIT;
    endcase

    // Outputs are forced idle for the whole reset cycle, not just after the edge.
    if (reset) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      data_write = 1'b0;
      alu_write  = 1'b0;
      zero_write = 1'b0;
      alu_src1   = SRC1_PC;
      alu_src2   = SRC2_RD2;
      alu_op     = ALU_ADD;
      result_src = RES_ALU_OUT;
      halted     = 1'b0;
    end
  end

  assign retired = retired_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = illegal_q & ~reset;
`else
  assign illegal = 1'b0;
`endif

endmodule
